// File: rtl/mips_pkg.sv
// Shared definitions for the boot loader: state encoding and framing constants.
package mips_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HDR_HI = 3'd1;
   localparam logic [2:0] ST_HDR_LO = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;
   localparam logic [2:0] ST_RUN    = 3'd5;
   localparam logic [2:0] ST_ERROR  = 3'd6;

   localparam int          HDR_BYTES      = 2;
   localparam int          WORD_BYTES     = 4;
   localparam logic [31:0] INST_ADDR_STEP = 32'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_HDR_HI = ST_HDR_HI,
      S_HDR_LO = ST_HDR_LO,
      S_DATA   = ST_DATA,
      S_WRITE  = ST_WRITE,
      S_RUN    = ST_RUN,
      S_ERROR  = ST_ERROR
   } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; word_full_o flags that the
// next shifted byte completes the word.
module word_assembler
   import mips_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        shift_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [31:0] shreg_q;
   logic [1:0]  cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (clear_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (shift_en_i) begin
         shreg_q <= {shreg_q[23:0], byte_i};
         cnt_q   <= cnt_q + 2'd1;
      end
   end

   assign word_o      = shreg_q;
   assign word_full_o = (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: receives a word count and image, writes it to
// instruction memory and holds the core PC in reset until the image is complete.
module program_loader
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          MAX_WORDS      = 256,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        inst_memory_load_enable,
   output logic [31:0] inst_memory_write_addr,
   output logic [31:0] inst_memory_write_data,
   output logic        PC_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);
   localparam logic [31:0] IDLE_LIMIT  = 32'(TIMEOUT_CYCLES - 1);

   loader_state_e state_q, state_d;
   logic [7:0]    n_hi_q, n_hi_d;
   logic [15:0]   n_q, n_d;
   logic [15:0]   word_idx_q, word_idx_d;
   logic [31:0]   idle_q, idle_d;
   logic          byte_ready_q, load_en_q, pc_reset_q, busy_q, done_q, error_q;
   logic [31:0]   addr_q;

   logic          accept, in_rx, rx_d;
   logic          asm_clear, asm_shift, asm_full;
   logic [31:0]   asm_word;
   logic [15:0]   n_rx;

   assign accept = byte_valid & byte_ready_q;
   assign in_rx  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
   assign rx_d   = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_DATA);
   assign n_rx   = {n_hi_q, byte_data};

   always_comb begin
      state_d    = state_q;
      n_hi_d     = n_hi_q;
      n_d        = n_q;
      word_idx_d = word_idx_q;
      idle_d     = idle_q;
      asm_clear  = 1'b0;
      asm_shift  = 1'b0;

      // Any receive state aborts once the link has been silent for too long.
      if (in_rx) begin
         if (accept) begin
            idle_d = '0;
         end else if (idle_q == IDLE_LIMIT) begin
            state_d   = S_ERROR;
            asm_clear = 1'b1;
         end else begin
            idle_d = idle_q + 32'd1;
         end
      end

      case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            if (start) begin
               state_d   = S_HDR_HI;
               asm_clear = 1'b1;
            end
         end
         S_HDR_HI: begin
            if (accept) begin
               n_hi_d  = byte_data;
               state_d = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (accept) begin
               n_d        = n_rx;
               word_idx_d = '0;
               asm_clear  = 1'b1;
               if ((n_rx == 16'd0) || ({1'b0, n_rx} > MAX_WORDS_W))
                  state_d = S_ERROR;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               asm_shift = 1'b1;
               if (asm_full)
                  state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (word_idx_q == n_q - 16'd1) begin
               state_d = S_RUN;
            end else begin
               word_idx_d = word_idx_q + 16'd1;
               state_d    = S_DATA;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q)
         idle_d = '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         n_hi_q       <= '0;
         n_q          <= '0;
         word_idx_q   <= '0;
         idle_q       <= '0;
         byte_ready_q <= 1'b0;
         load_en_q    <= 1'b0;
         pc_reset_q   <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         addr_q       <= BASE_ADDR;
      end else begin
         state_q      <= state_d;
         n_hi_q       <= n_hi_d;
         n_q          <= n_d;
         word_idx_q   <= word_idx_d;
         idle_q       <= idle_d;
         // Outputs are registered from the next state so they line up with it.
         byte_ready_q <= rx_d;
         load_en_q    <= (state_d == S_WRITE);
         pc_reset_q   <= (state_d != S_RUN);
         busy_q       <= rx_d || (state_d == S_WRITE);
         done_q       <= (state_d == S_RUN);
         error_q      <= (state_d == S_ERROR);
         if ((state_d == S_WRITE) && (state_q != S_WRITE))
            addr_q <= BASE_ADDR + {16'd0, word_idx_q} * INST_ADDR_STEP;
      end
   end

   word_assembler u_asm (
      .clk_i       (clock),
      .rst_ni      (reset_n),
      .clear_i     (asm_clear),
      .shift_en_i  (asm_shift),
      .byte_i      (byte_data),
      .word_o      (asm_word),
      .word_full_o (asm_full)
   );

   assign byte_ready              = byte_ready_q;
   assign inst_memory_load_enable = load_en_q;
   assign inst_memory_write_addr  = addr_q;
   assign inst_memory_write_data  = asm_word;
   assign PC_reset                = pc_reset_q;
   assign busy                    = busy_q;
   assign done                    = done_q;
   assign error                   = error_q;

endmodule
